// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix multiplier and its companion blocks:
//   - default array size, operand width and multiplier pipeline depth
//   - mm_latency(): cycles from operand presentation to a settled C matrix
//   - stream_state_t: state encoding of the result streamer
// ---------------------------------------------------------------------------
package matrix_pkg;

   localparam int N_DEF           = 4;
   localparam int WIDTH_DEF       = 16;
   localparam int PIPE_STAGES_DEF = 2;

   // The array needs its pipeline depth plus N skewed wavefront steps plus
   // one output register before C is complete.
   function automatic int mm_latency(input int n, input int pipe_stages);
      return pipe_stages + n + 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      STREAM
   } stream_state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// ---------------------------------------------------------------------------
// matrix_index_counter
// Row-major (row, col) walker over an N x N matrix.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (indices -> 0)
//   clear       - synchronous return to (0,0); wins over enable
//   enable      - advance one element; (N-1,N-1) wraps to (0,0)
//   row, col    - current indices
//   is_last     - high while the indices point at (N-1,N-1)
// ---------------------------------------------------------------------------
module matrix_index_counter
   import matrix_pkg::*;
#(
   parameter int N = N_DEF,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          enable,
   output logic [IW-1:0] row,
   output logic [IW-1:0] col,
   output logic          is_last
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (enable) begin
         if (col == LAST_IDX) begin
            col <= '0;
            row <= (row == LAST_IDX) ? '0 : row + IW'(1);
         end else begin
            col <= col + IW'(1);
         end
      end
   end

   assign is_last = (row == LAST_IDX) && (col == LAST_IDX);

endmodule

// File: rtl/matrix_result_streamer.sv
// ---------------------------------------------------------------------------
// matrix_result_streamer
// Waits LATENCY edges after a start pulse, snapshots the N x N product matrix
// and streams it row-major over a valid/ready interface.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - drain request, only honoured while idle
//   C                   - product matrix from the multiplier array
//   busy                - high while waiting for C or streaming
//   out_valid/out_ready - element handshake
//   out_data            - current element (2*WIDTH bits, passed unmodified)
//   out_row, out_col    - indices of out_data
//   out_last            - marks element (N-1,N-1)
// ---------------------------------------------------------------------------
module matrix_result_streamer
   import matrix_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int LATENCY = mm_latency(N, PIPE_STAGES_DEF),
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   C [N][N],
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_data,
   output logic [IW-1:0]        out_row,
   output logic [IW-1:0]        out_col,
   output logic                 out_last
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] LAT = CW'(LATENCY);

   stream_state_t        state;
   logic [CW-1:0]        wait_cnt;
   logic [2*WIDTH-1:0]   snap [N][N];
   logic                 capture;
   logic                 advance;
   logic                 is_last;

   assign capture = (state == WAIT) && (wait_cnt == LAT);
   assign advance = (state == STREAM) && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WAIT;
                  wait_cnt <= CW'(1);
                  busy     <= 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt == LAT) begin
                  state     <= STREAM;
                  out_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            STREAM: begin
               if (out_ready && is_last) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Snapshot decouples the stream from later changes on C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               snap[r][c] <= '0;
      end else if (capture) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               snap[r][c] <= C[r][c];
      end
   end

   // The counter wraps to (0,0) on the final handshake, so row/col read 0
   // whenever the block is not streaming.
   matrix_index_counter #(
      .N(N)
   ) u_index (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (capture),
      .enable (advance),
      .row    (out_row),
      .col    (out_col),
      .is_last(is_last)
   );

   // Decoded from registered state only; out_ready never reaches these.
   assign out_data = out_valid ? snap[out_row][out_col] : '0;
   assign out_last = out_valid && is_last;

endmodule
